// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcodes, bubble encoding,
// decode-stage controller states and the IF/ID bundle.
package core_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug; sticks at all-ones,
// cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencing: owns IF/ID, resolves load-use stalls,
// redirect flushes and ECALL halt, and tracks stall/flush counts.
module hazard_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_INST = core_pkg::NOP_INST,
    parameter int          CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             f_valid,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_inst,
    output logic             f_ready,
    output logic             d_valid,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_inst,
    input  logic [6:0]       d_opcode,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             x_valid,
    input  logic [4:0]       x_rd,
    input  logic             x_is_load,
    input  logic             x_redirect,
    output logic             issue_valid,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t state, state_nxt;
    if_id_t ifid, ifid_nxt;

    logic load_use;
    logic redirect;
    logic is_ecall;
    logic stall_inc;
    logic flush_inc;

    assign load_use = ifid.valid & x_valid & x_is_load
                    & (x_rd != 5'd0)
                    & ((x_rd == d_rs1) | (x_rd == d_rs2));
    assign redirect = x_valid & x_redirect;
    assign is_ecall = ifid.valid & (d_opcode == OP_SYSTEM);

    always_comb begin
        state_nxt   = state;
        ifid_nxt    = ifid;
        f_ready     = 1'b1;
        issue_valid = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect) begin
                    ifid_nxt.valid = 1'b0;
                    ifid_nxt.pc    = 32'h0;
                    ifid_nxt.inst  = NOP_INST;
                    flush_inc      = 1'b1;
                end else if (load_use) begin
                    f_ready   = 1'b0;
                    stall_inc = 1'b1;
                end else begin
                    issue_valid = ifid.valid;
                    if (is_ecall) begin
                        // ECALL issues; the word fetched alongside is dropped
                        state_nxt      = HALT;
                        ifid_nxt.valid = 1'b0;
                        ifid_nxt.inst  = NOP_INST;
                    end else begin
                        ifid_nxt.valid = f_valid;
                        ifid_nxt.pc    = f_pc;
                        ifid_nxt.inst  = f_valid ? f_inst : NOP_INST;
                    end
                end
            end
            HALT: begin
                f_ready        = 1'b0;
                ifid_nxt.valid = 1'b0;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            ifid.valid <= 1'b0;
            ifid.pc    <= 32'h0;
            ifid.inst  <= NOP_INST;
        end else begin
            state <= state_nxt;
            ifid  <= ifid_nxt;
        end
    end

    assign d_valid = ifid.valid;
    assign d_pc    = ifid.pc;
    assign d_inst  = ifid.inst;
    assign halted  = (state == HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .count   (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the decode stage of the RV32I pipelined core. It owns the IF/ID pipeline register that feeds the decode datapath, and detects load-use hazards against the EX stage. It inserts bubbles, flushes wrong-path instructions on EX redirects, and halts the front end after an ECALL issues. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- NOP_INST, 32'h00000013, bubble encoding (addi x0,x0,0) loaded into IF/ID on reset and flush
- CNT_W, 16, width of stall/flush counters

Ports:
- clock  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- f_valid  in  1  fetch presents a valid instruction
- f_pc  in  32  PC of fetched instruction
- f_inst  in  32  fetched instruction word
- f_ready  out  1  IF/ID accepts f_* this cycle; fetch advances PC only when f_valid&f_ready
- d_valid  out  1  IF/ID holds a real instruction
- d_pc  out  32  IF/ID PC, drives decode d_pc
- d_inst  out  32  IF/ID instruction, drives decode inst
- d_opcode  in  7  decoded opcode of d_inst
- d_rs1, d_rs2  in  5 each  decoded source registers (0 when unused)
- x_valid  in  1  ID/EX holds a real instruction
- x_rd  in  5  ID/EX destination register
- x_is_load  in  1  ID/EX instruction is a load (opcode 0000011)
- x_redirect  in  1  EX resolved a taken branch/JAL/JALR this cycle (qualified by x_valid)
- issue_valid  out  1  decoded instruction enters ID/EX at next edge; 0 means bubble
- halted  out  1  controller is in HALT
- stall_cnt  out  CNT_W  cycles spent in load-use stall, saturating
- flush_cnt  out  CNT_W  number of redirect flushes, saturating

## Operation
- FSM states are RUN and HALT. Reset enters RUN.
- load_use = d_valid & x_valid & x_is_load & (x_rd!=0) & (x_rd==d_rs1 | x_rd==d_rs2).
- redirect = x_valid & x_redirect.
- is_ecall = d_valid & (d_opcode==7'b1110011).
- Per-cycle priority in RUN:
  1. **redirect**: issue_valid=0 and f_ready=1. The f_* inputs are discarded. Next edge: d_valid<=0, d_inst<=NOP_INST, d_pc<=0, flush_cnt++.
  2. **load_use**: issue_valid=0 and f_ready=0. IF/ID holds. Next edge: stall_cnt++.
  3. **normal**: issue_valid=d_valid and f_ready=1. Next edge: d_valid<=f_valid, d_pc<=f_pc, d_inst<=(f_valid ? f_inst : NOP_INST).
  4. **is_ecall** with normal issue: the ECALL issues. Next edge: FSM->HALT, d_valid<=0, d_inst<=NOP_INST. The fetched word is not captured.
- HALT: f_ready=0, issue_valid=0, d_valid stays 0, counters frozen, halted=1. HALT is exited only by reset.
- Redirect in the same cycle as ECALL in ID: the redirect wins, the ECALL is wrong-path, and the FSM stays in RUN.
- Redirect in the same cycle as load_use: the redirect wins and stall_cnt does not increment.
- Counters stick at 2^CNT_W-1.
- x0 as a destination never causes a stall.

## Timing
- Reset values (asynchronous): state=RUN, d_valid=0, d_pc=0, d_inst=NOP_INST, stall_cnt=0, flush_cnt=0. Therefore f_ready=1, issue_valid=0 and halted=0 during and after reset.
- Deasserting reset_n mid-operation discards all in-flight IF/ID contents.
- f_ready, issue_valid and halted are combinational from registered state plus current inputs. There are no combinational paths from f_* to any output.
- Fetch-to-issue latency is 1 cycle: captured at edge N, issue_valid at cycle N.
- A load-use stall lasts exactly 1 cycle. After the stall, the load has left EX, so load_use drops.
- Redirect penalty: the cycle after a redirect shows d_valid=0. The target instruction is captured at the following edge if f_valid.

## Structure
- Shared package core_pkg: opcode constants (OP_LOAD=7'b0000011, OP_SYSTEM=7'b1110011, OP_BRANCH, OP_JAL, OP_JALR), NOP_INST, and the state enum {RUN, HALT}. The decoder uses the same constants.
- One sub-module, sat_counter (width parameter, inc, clear-by-reset, count out), instantiated twice for stall_cnt and flush_cnt.
- The IF/ID register and the FSM stay in the top module.

## Test plan
- **Reset**: hold reset_n=0 with f_valid=1 -> d_valid=0, d_inst=32'h00000013, f_ready=1, counters 0. After release, the first f_inst is captured at the next edge.
- **Load-use**: ID holds add x3,x1,x2 while EX holds lw x1 with x_valid=1 -> exactly 1 cycle of issue_valid=0 and f_ready=0, d_inst unchanged, stall_cnt=1. Repeating with lw x0 gives no stall.
- **Flush**: x_redirect=1 while ID is valid and f_valid=1 -> next cycle d_valid=0, d_inst=NOP_INST, flush_cnt=1, and the discarded f_inst never appears on d_inst.
- **Redirect beats load-use**: redirect and load_use asserted together -> flush occurs, stall_cnt unchanged, flush_cnt increments.
- **ECALL halt**: ECALL (32'h00000073) in ID with no redirect -> issue_valid=1 that cycle, then halted=1, f_ready=0 and issue_valid=0 for 20 cycles. With a redirect in the same cycle, the controller stays in RUN.
- **Saturation and async reset**: force 70000 stalls -> stall_cnt=16'hFFFF. Asserting reset_n low mid-stall immediately clears all state without a clock edge.
